alu_op_driver: RTL and testbench

ALU_OP_DRIVER -- requirements
Module: alu_op_driver

---
 rtl/alu_op_driver.sv | 124 ++++++++++++
 tb/tb_alu_op_driver.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_driver.sv
// Sequences commands into an external combinational ALU: drives operands, waits SETTLE
// cycles, captures the result and holds it until the consumer accepts it.
module alu_op_driver #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_oper,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_oper,
  input  logic [WIDTH-1:0] alu_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  localparam int unsigned CW   = 4;
  localparam int unsigned OPW  = 3;
  localparam int unsigned CNTW = 16;
  localparam logic [OPW-1:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [WIDTH-1:0]  acc, acc_d;
  logic              acc_valid, acc_valid_d;
  logic              cmd_ready_d;
  logic [WIDTH-1:0]  alu_a_d, alu_b_d, rsp_data_d;
  logic [OPW-1:0]    alu_oper_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [CNTW-1:0]   op_count_d;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    acc_d       = acc;
    acc_valid_d = acc_valid;
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_oper_d  = alu_oper;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    rsp_valid_d = rsp_valid;
    op_count_d  = op_count;
    cmd_ready_d = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d    = (cmd_chain && acc_valid) ? acc : cmd_a;
          alu_b_d    = cmd_b;
          alu_oper_d = cmd_oper;
          cnt_d      = CW'(SETTLE);
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt - CW'(1);
        // Last settle cycle: the ALU output is stable now
        if (cnt == CW'(1)) begin
          rsp_data_d  = alu_sum;
          rsp_err_d   = (alu_oper == OP_ZERO);
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          acc_d       = rsp_data;
          acc_valid_d = 1'b1;
          op_count_d  = op_count + CNTW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      cmd_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_oper  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      acc       <= acc_d;
      acc_valid <= acc_valid_d;
      cmd_ready <= cmd_ready_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_oper  <= alu_oper_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      rsp_valid <= rsp_valid_d;
      op_count  <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: SETTLE=1 instance for the main flow,
// SETTLE=4 instance for the mid-transaction reset scenario.
module tb_alu_op_driver;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic [2:0]   cmd_oper = '0;
  logic         cmd_chain = 1'b0;
  logic         rsp_ready = 1'b0;

  logic         cmd_ready, rsp_valid, rsp_err;
  logic [W-1:0] alu_a, alu_b, alu_sum, rsp_data;
  logic [2:0]   alu_oper;
  logic [15:0]  op_count;

  logic         cmd_ready4, rsp_valid4, rsp_err4;
  logic [W-1:0] alu_a4, alu_b4, alu_sum4, rsp_data4;
  logic [2:0]   alu_oper4;
  logic [15:0]  op_count4;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_d_q[$];
  logic         exp_e_q[$];
  logic [W-1:0] acc_m = '0;
  logic         acc_valid_m = 1'b0;
  logic [15:0]  cnt_m = '0;

  always #5 clk = ~clk;

  // External ALU model
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return b - a;
      3'd3:    return a | b;
      3'd4:    return a & b;
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  assign alu_sum  = alu_f(alu_a, alu_b, alu_oper);
  assign alu_sum4 = alu_f(alu_a4, alu_b4, alu_oper4);

  alu_op_driver #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_sum(alu_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_op_driver #(.WIDTH(W), .SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper), .cmd_chain(cmd_chain),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_oper(alu_oper4), .alu_sum(alu_sum4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
    .rsp_err(rsp_err4), .op_count(op_count4)
  );

  // Offer one command to the SETTLE=1 instance and push its expected response
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic chain);
    int n = 0;
    logic [W-1:0] eff;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
    end
    eff = (chain && acc_valid_m) ? acc_m : a;
    exp_d_q.push_back(alu_f(eff, b, op));
    exp_e_q.push_back(op == 3'b111);
    cmd_a = a; cmd_b = b; cmd_oper = op; cmd_chain = chain; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_chain = 1'b0;
  endtask

  // Wait for a response, compare against the scoreboard, optionally stall, then accept
  task automatic recv(output logic [W-1:0] obs, output int lat, input int hold);
    logic [W-1:0] ed;
    logic ee;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    ed = exp_d_q.pop_front();
    ee = exp_e_q.pop_front();
    obs = rsp_data;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    checks++;
    if (rsp_data !== ed) begin
      errors++; $display("FAIL rsp_data: got %h required %h", rsp_data, ed);
    end
    checks++;
    if (rsp_err !== ee) begin
      errors++; $display("FAIL rsp_err: got %b required %b", rsp_err, ee);
    end
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_a = W'($urandom); cmd_b = W'($urandom);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== obs || rsp_err !== ee || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: valid=%b data=%h err=%b ready=%b required 1 %h %b 0",
                 rsp_valid, rsp_data, rsp_err, cmd_ready, obs, ee);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc_m = ed; acc_valid_m = 1'b1; cnt_m++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL post_handshake: rsp_valid=%b cmd_ready=%b required 0 1",
                         rsp_valid, cmd_ready);
    end
    checks++;
    if (op_count !== cnt_m) begin
      errors++; $display("FAIL op_count: got %0d required %0d", op_count, cnt_m);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_oper, rsp_data, rsp_err, rsp_valid, op_count} !== '0) begin
      errors++; $display("FAIL reset_outputs: a=%h b=%h op=%h d=%h e=%b v=%b cnt=%0d required 0",
                         alu_a, alu_b, alu_oper, rsp_data, rsp_err, rsp_valid, op_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b required 1 0",
                         cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_add;
    logic [W-1:0] obs; int lat;
    send(W'(5), W'(7), 3'b000, 1'b0);
    recv(obs, lat, 0);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d required 1", lat); end
    checks++;
    if (obs !== W'(12)) begin errors++; $display("FAIL add_data: got %0d required 12", obs); end
    checks++;
    if (op_count !== 16'd1) begin
      errors++; $display("FAIL add_count: got %0d required 1", op_count);
    end
  endtask

  task automatic test_chain;
    logic [W-1:0] obs; int lat;
    send(W'(1000), W'(2), 3'b001, 1'b1);
    @(negedge clk);
    checks++;
    if (alu_a !== W'(12) || alu_b !== W'(2) || alu_oper !== 3'b001) begin
      errors++; $display("FAIL chain_operands: a=%0d b=%0d op=%0d required 12 2 1",
                         alu_a, alu_b, alu_oper);
    end
    recv(obs, lat, 0);
    checks++;
    if (obs !== W'(10)) begin errors++; $display("FAIL chain_data: got %0d required 10", obs); end
  endtask

  task automatic test_wrap;
    logic [W-1:0] obs, ones; int lat;
    ones = '1;
    send(W'(0), W'(1), 3'b001, 1'b0);
    recv(obs, lat, 0);
    checks++;
    if (obs !== ones) begin errors++; $display("FAIL wrap_data: got %h required %h", obs, ones); end
  endtask

  task automatic test_ops;
    logic [W-1:0] obs; int lat;
    for (int op = 2; op <= 6; op++) begin
      send({32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, 3'(op), 1'b0);
      recv(obs, lat, 0);
    end
    send(W'(3), W'(40), 3'b010, 1'b1);
    recv(obs, lat, 0);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] obs; int lat;
    send(W'(100), W'(23), 3'b000, 1'b0);
    recv(obs, lat, 5);
    checks++;
    if (obs !== W'(123)) begin errors++; $display("FAIL bp_data: got %0d required 123", obs); end
  endtask

  task automatic test_op111;
    logic [W-1:0] obs; int lat;
    send(W'(3), W'(4), 3'b111, 1'b0);
    recv(obs, lat, 0);
    checks++;
    if (obs !== W'(0)) begin errors++; $display("FAIL op111_data: got %0d required 0", obs); end
    send(W'(99), W'(5), 3'b000, 1'b1);
    recv(obs, lat, 0);
    checks++;
    if (obs !== W'(5)) begin errors++; $display("FAIL op111_acc: got %0d required 5", obs); end
  endtask

  task automatic test_ready_idle;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== cnt_m) begin
        errors++; $display("FAIL ready_idle: valid=%b cnt=%0d required 0 %0d",
                           rsp_valid, op_count, cnt_m);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc_cyc[$];
    logic [W-1:0] ed;
    logic ee;
    rsp_ready = 1'b1;
    cmd_chain = 1'b0; cmd_oper = 3'b000; cmd_b = W'(7);
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        ed = exp_d_q.pop_front(); ee = exp_e_q.pop_front();
        checks++;
        if (rsp_data !== ed || rsp_err !== ee) begin
          errors++; $display("FAIL b2b_data: got %h/%b required %h/%b", rsp_data, rsp_err, ed, ee);
        end
        acc_m = ed; acc_valid_m = 1'b1; cnt_m++;
      end
      if (cmd_ready && acc_cyc.size() < 4) begin
        cmd_a = W'(cyc * 3);
        exp_d_q.push_back(alu_f(cmd_a, cmd_b, 3'b000));
        exp_e_q.push_back(1'b0);
        acc_cyc.push_back(cyc);
        cmd_valid = 1'b1;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (acc_cyc.size() != 4) begin
      errors++; $display("FAIL b2b_accepts: got %0d required 4", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
        errors++; $display("FAIL b2b_interval: got %0d required 3", acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    checks++;
    if (op_count !== cnt_m || exp_d_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: cnt=%0d pending=%0d required %0d 0",
                         op_count, exp_d_q.size(), cnt_m);
    end
  endtask

  task automatic test_reset_mid_drive;
    int seen = 0;
    int n = 0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_d_q.delete(); exp_e_q.delete();
    acc_m = '0; acc_valid_m = 1'b0; cnt_m = '0;
    @(negedge clk);
    checks++;
    if (cmd_ready4 !== 1'b1) begin
      errors++; $display("FAIL mid_pre_ready: got %b required 1", cmd_ready4);
    end
    cmd_a = W'(20); cmd_b = W'(22); cmd_oper = 3'b000; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid4) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_no_rsp: valid cycles %0d required 0", seen); end
    checks++;
    if ({alu_a4, alu_b4, alu_oper4, rsp_data4, rsp_err4, op_count4} !== '0 || cmd_ready4 !== 1'b1) begin
      errors++; $display("FAIL mid_cleared: a=%h b=%h op=%h d=%h e=%b cnt=%0d rdy=%b required 0s rdy 1",
                         alu_a4, alu_b4, alu_oper4, rsp_data4, rsp_err4, op_count4, cmd_ready4);
    end
    cmd_a = W'(9); cmd_b = W'(1); cmd_oper = 3'b000; cmd_chain = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; cmd_chain = 1'b0;
    @(negedge clk);
    while (!rsp_valid4 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid4 !== 1'b1 || rsp_data4 !== W'(10) || rsp_err4 !== 1'b0) begin
      errors++; $display("FAIL mid_followup: valid=%b data=%0d err=%b required 1 10 0",
                         rsp_valid4, rsp_data4, rsp_err4);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (op_count4 !== 16'd1 || rsp_valid4 !== 1'b0) begin
      errors++; $display("FAIL mid_count: cnt=%0d valid=%b required 1 0", op_count4, rsp_valid4);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_chain;
    test_wrap;
    test_ops;
    test_backpressure;
    test_op111;
    test_ready_idle;
    test_back_to_back;
    test_reset_mid_drive;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
